spec_ram_writer: RTL and testbench
==================================

Name: spec_ram_writer

Overview:
- Writer side of the reference-spectrum RAM that the FFT→complex-multiply→IFFT path reads.
- Captures one FFT output frame from an AXI-Stream master (real/imag, bin index in tuser, tlast).
- Writes bins BIN_LO..BIN_HI into the real/imag RAM write port at address = index − BIN_LO. This matches the read side, which fetches address i−4 at index i so that the data is ready for bin i+1.
- Sits between the capture-mode FFT instance and the dual-port spectrum RAMs.

Parameters:
- DATA_W, 16, width of each real/imag component
- IDX_W, 13, bin index width (frame length 2^IDX_W = 8192)
- ADDR_W, 12, RAM address width
- BIN_LO, 5, first stored bin (stored at address 0)
- BIN_HI, 2750, last stored bin (stored at address 2745)
- SCALE_SH, 0, right-shift applied when SPEC_WR_SCALE_EN is defined

Ports:
- fft_clk, in, 1, single clock
- sys_rst, in, 1, reset (synchronous, active-high)
- capture_start, in, 1, level; its rising edge arms a capture
- s_axis_tdata, in, 2*DATA_W, [DATA_W-1:0] real, [2*DATA_W-1:DATA_W] imag, signed
- s_axis_tuser, in, IDX_W, bin index of the beat
- s_axis_tvalid, in, 1, beat valid
- s_axis_tlast, in, 1, last beat of frame
- s_axis_tready, out, 1, high in ARM and CAPTURE only
- wr_en, out, 1, RAM write strobe
- wr_addr, out, ADDR_W, RAM address
- wr_real, out, DATA_W, real data to RAM
- wr_imag, out, DATA_W, imag data to RAM
- busy, out, 1, high in ARM or CAPTURE
- done, out, 1, one-cycle pulse at frame end
- bins_written, out, ADDR_W+1, count of writes in the current/last capture
- err_frame, out, 1, sticky; a sequence or tlast error occurred this capture

Behaviour:
- Reset: all outputs 0, state IDLE, edge-detect register 0. Reset mid-capture abandons the frame and performs no further writes.
- Accept = s_axis_tvalid & s_axis_tready.
- Rising edge of capture_start is detected with a registered previous value. The edge is acted on only in IDLE; edges in other states are ignored.
- IDLE:
  - tready=0.
  - On an edge: clear bins_written and err_frame, go to ARM.
- ARM:
  - tready=1. Accepted beats with tuser≠0 are discarded.
  - An accepted beat with tuser==0 goes to CAPTURE, sets expected index = 1, and processes that beat (bin 0 is out of window, so no write).
- CAPTURE, per accepted beat:
  - If BIN_LO ≤ tuser ≤ BIN_HI: on the next cycle wr_en=1, wr_addr = tuser − BIN_LO (truncated to ADDR_W), wr_real/wr_imag = registered tdata; bins_written increments on that same cycle.
  - Write latency is exactly 1 cycle from accept. Out-of-window beats give wr_en=0.
  - If tuser ≠ expected index, set err_frame. The beat is still written if in window, and expected index becomes tuser+1.
  - If tlast is accepted, or tuser == 2^IDX_W−1 without tlast: go to DONE. Set err_frame if tlast arrives at tuser ≠ 2^IDX_W−1, or if tlast is absent at the final index.
- DONE:
  - One cycle. done=1, tready=0, go to IDLE.
  - The final beat's write, if any, occurs in this cycle, so wr_en and done may coincide.
- wr_en is 0 whenever no write is issued. wr_addr and wr_real/wr_imag hold their last values.
- A full capture writes BIN_HI−BIN_LO+1 = 2746 entries; bins_written = 2746.
- Gaps in tvalid stall the capture with no timeout. capture_start is not re-armed until DONE→IDLE completes.

Optional Feature:
- Macro: SPEC_WR_SCALE_EN.
- Defined: each component is arithmetically right-shifted by SCALE_SH with round-half-up (add 2^(SCALE_SH−1) before the shift, when SCALE_SH>0), then saturated to the signed DATA_W range. This is combinational inside the write register stage, so latency stays 1.
- Undefined: data passes through unchanged and SCALE_SH is ignored.

Decomposition:
- Shared package spec_ram_pkg holds:
  - typedef for the state enum (IDLE, ARM, CAPTURE, DONE)
  - cplx_t struct (re, im, DATA_W signed)
  - constants BIN_LO=5, BIN_HI=2750, SPEC_DEPTH=2746
  - these are also used by the read side
- One natural sub-module: spec_wr_scale, the round/saturate datapath for a single component, instantiated twice. Under the macro off it reduces to a pass-through.

Test Plan:
- Clean frame: edge on capture_start, then 8192 contiguous beats with tuser=0..8191, tdata={imag=−i, real=i}, tlast on 8191 → 2746 writes, addr 0 holds {−5,5}, addr 2745 holds {−2750,2750}; done pulses once; err_frame=0; bins_written=2746.
- Mid-frame arm: arm while the stream is at tuser=3000 → beats discarded until tuser=0; then a full capture exactly as above.
- Backpressure/gaps: tvalid toggled 50% pseudo-random over a full frame → identical RAM contents; every write occurs exactly 1 cycle after its accept.
- Errors: tuser skips 100→102 → err_frame=1, bin 102 written at addr 97. Separately, tlast at tuser=4000 → DONE, err_frame=1, bins_written=2746.
- Reset at tuser=1000 during CAPTURE → next cycle all outputs 0 and state IDLE; no wr_en until a new edge plus tuser=0.
- With SPEC_WR_SCALE_EN, SCALE_SH=2: real=7→2, real=−7→−2, real=32767→8192, wr_en latency still 1.

Source files
------------

// File: rtl/spec_ram_pkg.sv
// Shared definitions for the reference-spectrum RAM writer and reader.
// Holds the stored bin window, the capture FSM states and the complex sample type.
package spec_ram_pkg;

  localparam int DATA_W     = 16;
  localparam int IDX_W      = 13;
  localparam int ADDR_W     = 12;
  localparam int BIN_LO     = 5;
  localparam int BIN_HI     = 2750;
  localparam int SPEC_DEPTH = BIN_HI - BIN_LO + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DONE
  } spec_wr_state_e;

  // Imag sits in the upper half so a cplx_t overlays the stream tdata layout directly.
  typedef struct packed {
    logic signed [DATA_W-1:0] im;
    logic signed [DATA_W-1:0] re;
  } cplx_t;

endpackage

// File: rtl/spec_wr_scale.sv
// Round-half-up arithmetic right shift with signed saturation for one component.
// Enabled by SPEC_WR_SCALE_EN; without it the sample passes through unchanged.
module spec_wr_scale #(
  parameter int DATA_W   = 16,
  parameter int SCALE_SH = 0
) (
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

`ifdef SPEC_WR_SCALE_EN
  localparam bit SCALE_EN = 1'b1;
`else
  localparam bit SCALE_EN = 1'b0;
`endif

  if (SCALE_EN && (SCALE_SH > 0)) begin : g_scale
    localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W:0] HALF    = (DATA_W+1)'(2 ** (SCALE_SH - 1));

    logic signed [DATA_W:0] rounded;
    logic signed [DATA_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    always_comb begin
      rounded = $signed({din[DATA_W-1], din}) + HALF;
      shifted = rounded >>> SCALE_SH;
      if (shifted > SAT_MAX) begin
        dout = SAT_MAX[DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
        dout = SAT_MIN[DATA_W-1:0];
      end else begin
        dout = shifted[DATA_W-1:0];
      end
    end
  end else begin : g_pass
    assign dout = din;
  end

endmodule

// File: rtl/spec_ram_writer.sv
// Captures one FFT output frame from AXI-Stream and writes bins BIN_LO..BIN_HI to the spectrum RAM.
// Optional per-component scaling is enabled with SPEC_WR_SCALE_EN (see spec_wr_scale).
module spec_ram_writer #(
  parameter int DATA_W   = spec_ram_pkg::DATA_W,
  parameter int IDX_W    = spec_ram_pkg::IDX_W,
  parameter int ADDR_W   = spec_ram_pkg::ADDR_W,
  parameter int BIN_LO   = spec_ram_pkg::BIN_LO,
  parameter int BIN_HI   = spec_ram_pkg::BIN_HI,
  parameter int SCALE_SH = 0
) (
  input  logic                fft_clk,
  input  logic                sys_rst,
  input  logic                capture_start,
  input  logic [2*DATA_W-1:0] s_axis_tdata,
  input  logic [IDX_W-1:0]    s_axis_tuser,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_real,
  output logic [DATA_W-1:0]   wr_imag,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     bins_written,
  output logic                err_frame
);
  import spec_ram_pkg::*;

  localparam logic [IDX_W-1:0] LO_IDX   = IDX_W'(BIN_LO);
  localparam logic [IDX_W-1:0] HI_IDX   = IDX_W'(BIN_HI);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  spec_wr_state_e    state_q, state_d;
  logic              start_q;
  logic              start_edge;
  logic [IDX_W-1:0]  exp_idx_q;
  logic [IDX_W-1:0]  exp_cmp;
  logic              accept;
  logic              take;
  logic              in_win;
  logic              is_final;
  logic              frame_end;
  logic              seq_err;
  logic [DATA_W-1:0] real_scaled;
  logic [DATA_W-1:0] imag_scaled;

  spec_wr_scale #(.DATA_W(DATA_W), .SCALE_SH(SCALE_SH)) u_scale_re (
    .din  (s_axis_tdata[DATA_W-1:0]),
    .dout (real_scaled)
  );

  spec_wr_scale #(.DATA_W(DATA_W), .SCALE_SH(SCALE_SH)) u_scale_im (
    .din  (s_axis_tdata[2*DATA_W-1:DATA_W]),
    .dout (imag_scaled)
  );

  // NOTE: every signal driven here gets a value on every path (state_d defaulted
  // before the case), otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    start_edge    = capture_start & ~start_q;
    s_axis_tready = (state_q == ARM) || (state_q == CAPTURE);
    busy          = s_axis_tready;
    done          = (state_q == DONE);
    accept        = s_axis_tvalid & s_axis_tready;
    // In ARM only the bin-0 beat starts the frame; every other beat is drained.
    take          = accept & ((state_q == CAPTURE) | (s_axis_tuser == '0));
    exp_cmp       = (state_q == ARM) ? '0 : exp_idx_q;
    in_win        = (s_axis_tuser >= LO_IDX) && (s_axis_tuser <= HI_IDX);
    is_final      = (s_axis_tuser == LAST_IDX);
    frame_end     = take & (s_axis_tlast | is_final);
    seq_err       = take & ((s_axis_tuser != exp_cmp) | (s_axis_tlast ^ is_final));

    state_d = state_q;
    unique case (state_q)
      IDLE:         if (start_edge) state_d = ARM;
      ARM, CAPTURE: begin
        if (frame_end) begin
          state_d = DONE;
        end else if (take) begin
          state_d = CAPTURE;
        end
      end
      DONE:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge fft_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      exp_idx_q    <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_real      <= '0;
      wr_imag      <= '0;
      bins_written <= '0;
      err_frame    <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= capture_start;
      wr_en   <= take & in_win;

      if (take) begin
        exp_idx_q <= s_axis_tuser + IDX_W'(1);
      end

      // Address and data hold between writes; only the strobe drops.
      if (take & in_win) begin
        wr_addr      <= ADDR_W'(s_axis_tuser - LO_IDX);
        wr_real      <= real_scaled;
        wr_imag      <= imag_scaled;
        bins_written <= bins_written + (ADDR_W+1)'(1);
      end

      if ((state_q == IDLE) && start_edge) begin
        bins_written <= '0;
        err_frame    <= 1'b0;
      end else if (seq_err) begin
        err_frame <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spec_ram_writer.sv
// Randomised self-checking bench for spec_ram_writer with a cycle-level reference model.
// Build with SPEC_WR_SCALE_EN defined to exercise the scaling path (SCALE_SH=2).
`timescale 1ns/1ps
module tb_spec_ram_writer;
  import spec_ram_pkg::*;

`ifdef SPEC_WR_SCALE_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif
  localparam int    FRAME    = 1 << IDX_W;
  localparam cplx_t SENTINEL = 32'hDEAD_BEEF;

  logic                fft_clk       = 1'b0;
  logic                sys_rst       = 1'b1;
  logic                capture_start = 1'b0;
  logic [2*DATA_W-1:0] s_axis_tdata  = '0;
  logic [IDX_W-1:0]    s_axis_tuser  = '0;
  logic                s_axis_tvalid = 1'b0;
  logic                s_axis_tlast  = 1'b0;
  logic                s_axis_tready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_real;
  logic [DATA_W-1:0]   wr_imag;
  logic                busy;
  logic                done;
  logic [ADDR_W:0]     bins_written;
  logic                err_frame;

  always #5 fft_clk = ~fft_clk;

  spec_ram_writer #(.SCALE_SH(SH)) dut (
    .fft_clk       (fft_clk),
    .sys_rst       (sys_rst),
    .capture_start (capture_start),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_real       (wr_real),
    .wr_imag       (wr_imag),
    .busy          (busy),
    .done          (done),
    .bins_written  (bins_written),
    .err_frame     (err_frame)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] ref_scale(input logic [DATA_W-1:0] v);
    int x;
    x = int'($signed(v));
    x = (x + ((1 << SH) / 2)) >>> SH;
    if (x > (1 << (DATA_W-1)) - 1) x = (1 << (DATA_W-1)) - 1;
    if (x < -(1 << (DATA_W-1)))    x = -(1 << (DATA_W-1));
    return DATA_W'(x);
  endfunction

  function automatic cplx_t ref_entry(input int bin);
    cplx_t c;
    c.re = ref_scale(DATA_W'(bin));
    c.im = ref_scale(DATA_W'(-bin));
    return c;
  endfunction

  function automatic logic [2*DATA_W-1:0] beat_data(input int idx);
    return {DATA_W'(-idx), DATA_W'(idx)};
  endfunction

  // Reference model: phase 0 idle, 1 armed, 2 capturing, 3 frame done.
  int                m_phase = 0;
  bit                m_prev  = 1'b0;
  bit                m_err   = 1'b0;
  bit                m_valid = 1'b0;
  int                m_exp   = 0;
  int                m_bins  = 0;
  bit                e_wr    = 1'b0;
  logic [ADDR_W-1:0] e_addr  = '0;
  cplx_t             e_data  = '0;

  cplx_t tb_ram [SPEC_DEPTH];
  int    wr_count   = 0;
  int    done_count = 0;

  task automatic model_step();
    int tu;
    bit acc;
    e_wr = 1'b0;
    if (sys_rst) begin
      m_phase = 0; m_prev = 1'b0; m_err = 1'b0; m_bins = 0; m_exp = 0;
      e_addr  = '0; e_data = '0; m_valid = 1'b1;
      return;
    end
    tu  = int'(s_axis_tuser);
    acc = s_axis_tvalid && (m_phase == 1 || m_phase == 2);
    case (m_phase)
      0: if (capture_start && !m_prev) begin
           m_phase = 1; m_bins = 0; m_err = 1'b0;
         end
      3: m_phase = 0;
      default: if (acc && (m_phase == 2 || tu == 0)) begin
        if (m_phase == 1) m_exp = 0;
        if (tu != m_exp) m_err = 1'b1;
        m_exp = tu + 1;
        if (tu >= BIN_LO && tu <= BIN_HI) begin
          e_wr      = 1'b1;
          e_addr    = ADDR_W'(tu - BIN_LO);
          e_data.re = ref_scale(s_axis_tdata[DATA_W-1:0]);
          e_data.im = ref_scale(s_axis_tdata[2*DATA_W-1:DATA_W]);
          m_bins++;
        end
        if (s_axis_tlast || tu == FRAME - 1) begin
          m_phase = 3;
          if (s_axis_tlast != (tu == FRAME - 1)) m_err = 1'b1;
        end else begin
          m_phase = 2;
        end
      end
    endcase
    m_prev = capture_start;
  endtask

  // Outputs are compared on the falling edge, midway between active edges.
  always @(negedge fft_clk) begin
    if (m_valid) begin
      check("tready",       s_axis_tready, (m_phase == 1 || m_phase == 2));
      check("busy",         busy,          (m_phase == 1 || m_phase == 2));
      check("done",         done,          (m_phase == 3));
      check("wr_en",        wr_en,         e_wr);
      check("wr_addr",      wr_addr,       e_addr);
      check("wr_data",      {wr_imag, wr_real}, e_data);
      check("bins_written", bins_written,  m_bins);
      check("err_frame",    err_frame,     m_err);
    end
    if (wr_en === 1'b1) begin
      wr_count++;
      if (int'(wr_addr) < SPEC_DEPTH) tb_ram[wr_addr] = {wr_imag, wr_real};
    end
    if (done === 1'b1) done_count++;
    model_step();
  end

  task automatic send_beat(input int idx, input bit last, input bit gaps,
                           input logic [2*DATA_W-1:0] data);
    int guard;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        s_axis_tvalid = 1'b0;
        @(posedge fft_clk); #1;
      end
    end
    s_axis_tvalid = 1'b1;
    s_axis_tuser  = IDX_W'(idx);
    s_axis_tlast  = last;
    s_axis_tdata  = data;
    guard = 0;
    forever begin
      @(negedge fft_clk);
      if (s_axis_tready === 1'b1) begin
        @(posedge fft_clk); #1;
        break;
      end
      guard++;
      if (guard > 64) begin
        check("accept_timeout", s_axis_tready, 1'b1);
        break;
      end
      @(posedge fft_clk); #1;
    end
  endtask

  task automatic send_range(input int lo, input int hi, input int last_at, input bit gaps);
    for (int i = lo; i <= hi; i++) send_beat(i, (i == last_at), gaps, beat_data(i));
  endtask

  task automatic arm();
    @(posedge fft_clk); #1 capture_start = 1'b1;
    @(posedge fft_clk); #1 capture_start = 1'b0;
  endtask

  task automatic new_frame();
    for (int i = 0; i < SPEC_DEPTH; i++) tb_ram[i] = SENTINEL;
    wr_count   = 0;
    done_count = 0;
  endtask

  task automatic finish_frame();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (4) @(posedge fft_clk);
    #1;
  endtask

  task automatic check_frame(input string name, input int exp_bins, input bit exp_err,
                             input int skip_bin);
    int    bad;
    cplx_t want;
    bad = 0;
    for (int b = BIN_LO; b <= BIN_HI; b++) begin
      want = (b == skip_bin) ? SENTINEL : ref_entry(b);
      if (tb_ram[b - BIN_LO] !== want) bad++;
    end
    check({name, "_ram_bad_entries"}, bad, 0);
    check({name, "_addr0"},    tb_ram[0],            ref_entry(BIN_LO));
    check({name, "_addr_top"}, tb_ram[SPEC_DEPTH-1], ref_entry(BIN_HI));
    check({name, "_done_cnt"}, done_count, 1);
    check({name, "_wr_cnt"},   wr_count,   exp_bins);
    check({name, "_bins"},     bins_written, exp_bins);
    check({name, "_err"},      err_frame,  exp_err);
  endtask

  initial begin
    repeat (3) @(posedge fft_clk);
    #1 sys_rst = 1'b0;
    check("reset_tready", s_axis_tready, 1'b0);
    check("reset_wr_en",  wr_en,         1'b0);
    check("reset_busy",   busy,          1'b0);
    check("reset_bins",   bins_written,  0);
    check("reset_err",    err_frame,     1'b0);

    new_frame(); arm();
    send_range(0, FRAME-1, FRAME-1, 1'b0);
    finish_frame();
    check_frame("clean", SPEC_DEPTH, 1'b0, -1);

    new_frame();
    fork
      begin
        send_range(3000, FRAME-1, -1, 1'b0);
        send_range(0, FRAME-1, FRAME-1, 1'b0);
      end
      begin
        repeat (5) @(posedge fft_clk);
        #1;
        arm();
      end
    join
    finish_frame();
    check_frame("midarm", SPEC_DEPTH, 1'b0, -1);

    new_frame(); arm();
    send_range(0, FRAME-1, FRAME-1, 1'b1);
    finish_frame();
    check_frame("gaps", SPEC_DEPTH, 1'b0, -1);

    new_frame(); arm();
    send_range(0, 100, -1, 1'b0);
    send_range(102, FRAME-1, FRAME-1, 1'b0);
    finish_frame();
    check_frame("skip", SPEC_DEPTH-1, 1'b1, 101);
    check("skip_addr97", tb_ram[97], ref_entry(102));

    new_frame(); arm();
    send_range(0, 4000, 4000, 1'b0);
    finish_frame();
    check_frame("early_tlast", SPEC_DEPTH, 1'b1, -1);

    new_frame(); arm();
    send_range(0, 999, -1, 1'b0);
    s_axis_tuser = IDX_W'(1000);
    s_axis_tdata = beat_data(1000);
    sys_rst      = 1'b1;
    @(posedge fft_clk); #1 sys_rst = 1'b0;
    check("rst_mid_wr_en", wr_en,        1'b0);
    check("rst_mid_busy",  busy,         1'b0);
    check("rst_mid_bins",  bins_written, 0);
    check("rst_mid_addr",  wr_addr,      0);
    s_axis_tuser = '0;
    s_axis_tdata = beat_data(0);
    repeat (10) @(posedge fft_clk);
    #1;
    check("rst_mid_writes", wr_count, 1000 - BIN_LO);
    finish_frame();

    new_frame(); arm();
    send_range(0, FRAME-1, FRAME-1, 1'b0);
    finish_frame();
    check_frame("after_rst", SPEC_DEPTH, 1'b0, -1);

`ifdef SPEC_WR_SCALE_EN
    new_frame(); arm();
    send_range(0, BIN_LO-1, -1, 1'b0);
    send_beat(BIN_LO,   1'b0, 1'b0, {DATA_W'(0), DATA_W'(7)});
    send_beat(BIN_LO+1, 1'b0, 1'b0, {DATA_W'(0), DATA_W'(-7)});
    send_beat(BIN_LO+2, 1'b1, 1'b0, {DATA_W'(0), DATA_W'(32767)});
    finish_frame();
    check("scale_pos7",  tb_ram[0].re, DATA_W'(2));
    check("scale_neg7",  tb_ram[1].re, DATA_W'(-2));
    check("scale_max",   tb_ram[2].re, DATA_W'(8192));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not complete, %0d vectors so far", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
